// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// ALU operation codes are shared with the main ALU users and the EX operand mux.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  typedef enum logic [1:0] {MUL, MULHU, DIVU, REMU} op_sel_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic logic is_div(op_sel_e op);
    return (op == DIVU) || (op == REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer that borrows the shared EX-stage ALU for every step.
// Optional build macro MULDIV_BYPASS_EN: trivial operands finish without any ALU steps.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [3:0]      alu_operand,
  input  logic [XLEN-1:0] alu_out
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_e          state_q, state_d;
  op_sel_e         op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // hi holds acc_hi (multiply) or rem (divide); lo holds mplier or quo; b holds mcand or divisor.
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;

  op_sel_e         op_in;
  logic            div_zero;
  logic            bypass;
  logic [XLEN-1:0] bypass_val;
  logic            carry;
  logic            accept;
  logic [XLEN-1:0] rem_s;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  assign op_in    = op_sel_e'(op_sel);
  assign div_zero = is_div(op_in) && (op_b == '0);

`ifdef MULDIV_BYPASS_EN
  assign bypass     = is_div(op_in) ? (op_b == XLEN'(1)) : ((op_a == '0) || (op_b == '0));
  assign bypass_val = (op_in == DIVU) ? op_a : '0;
`else
  assign bypass     = 1'b0;
  assign bypass_val = '0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    result_d    = result_q;
    alu_req     = 1'b0;
    alu_op1     = '0;
    alu_op2     = '0;
    alu_operand = ALU_ADD;
    carry       = 1'b0;
    accept      = 1'b0;
    rem_s       = '0;
    step_hi     = hi_q;
    step_lo     = lo_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d = op_in;
          if (div_zero) begin
            result_d = (op_in == DIVU) ? '1 : op_a;
            state_d  = DONE;
          end else if (bypass) begin
            result_d = bypass_val;
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(ITERS - 1);
            hi_d    = '0;
            b_d     = is_div(op_in) ? op_b : op_a;
            lo_d    = is_div(op_in) ? op_a : op_b;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        alu_req = 1'b1;
        if (!is_div(op_q)) begin
          alu_op1 = hi_q;
          alu_op2 = lo_q[0] ? b_q : '0;
          // The ALU has no carry-out, so recover it from wrap-around.
          carry   = (alu_out < hi_q);
          step_hi = {carry, alu_out[XLEN-1:1]};
          step_lo = {alu_out[0], lo_q[XLEN-1:1]};
        end else begin
          alu_operand = ALU_SUB;
          rem_s       = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          alu_op1     = rem_s;
          alu_op2     = b_q;
          accept      = hi_q[XLEN-1] || (rem_s >= b_q);
          step_hi     = accept ? alu_out : rem_s;
          step_lo     = {lo_q[XLEN-2:0], accept};
        end
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = (op_q == MUL || op_q == DIVU) ? step_lo : step_hi;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (kill && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE) && !kill;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural model of the shared ALU.
// Latency expectations for trivial operands follow the MULDIV_BYPASS_EN build macro.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_sel = 2'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_operand;
  logic [31:0] alu_out;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_BYPASS_EN
  localparam int TRIV_LAT = 1;
`else
  localparam int TRIV_LAT = 33;
`endif

  always #5 clk = ~clk;

  // Main ALU stand-in: combinational add/subtract.
  assign alu_out = (alu_operand == ALU_SUB) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
    .kill(kill), .busy(busy), .done(done), .result(result), .alu_req(alu_req),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operand(alu_operand), .alu_out(alu_out)
  );

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issues one operation (start sampled at edge 0) and records what happens until done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int done_cyc, output int req_first,
                        output int req_last, output int req_cnt, output int req_add,
                        output int req_sub);
    int cyc;
    bit seen;
    done_cyc = -1; req_first = -1; req_last = -1; req_cnt = 0; req_add = 0; req_sub = 0;
    res = 'x; seen = 0;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op_sel = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 1; cyc <= 60 && !seen; cyc++) begin
      if (alu_req) begin
        if (req_first < 0) req_first = cyc;
        req_last = cyc;
        req_cnt++;
        if (alu_operand == ALU_ADD) req_add++;
        if (alu_operand == ALU_SUB) req_sub++;
      end
      if (done) begin
        seen = 1; done_cyc = cyc; res = result;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL timeout op=%0d a=%h b=%h: no done within 60 cycles", op, a, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (alu_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_alu_req got %b want 0", alu_req); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 0", result); end
    checks++; if (alu_op1 !== 32'h0 || alu_op2 !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_alu_ops got %h/%h want 0/0", alu_op1, alu_op2);
    end
    checks++; if (alu_operand !== ALU_ADD) begin errors++; $display("[TB] FAIL reset_alu_operand got %h want 0", alu_operand); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; int dc, rf, rl, rc, ra, rs;
    run_op(2'd0, 32'd7, 32'd6, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'h0000002A) begin errors++; $display("[TB] FAIL mul_7x6 got %h want 0000002a", r); end
    checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL mul_latency got %0d want 33", dc); end
    checks++; if (rf !== 1 || rl !== 32 || rc !== 32) begin
      errors++; $display("[TB] FAIL mul_alu_req got first=%0d last=%0d count=%0d want 1/32/32", rf, rl, rc);
    end
    checks++; if (ra !== 32) begin errors++; $display("[TB] FAIL mul_operand got %0d ADD cycles want 32", ra); end
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu_max got %h want fffffffe", r); end
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'h00000001) begin errors++; $display("[TB] FAIL mul_max got %h want 00000001", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int dc, rf, rl, rc, ra, rs;
    run_op(2'd2, 32'd100, 32'd7, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd14) begin errors++; $display("[TB] FAIL divu_100_7 got %0d want 14", r); end
    checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL divu_latency got %0d want 33", dc); end
    checks++; if (rs !== 32) begin errors++; $display("[TB] FAIL divu_operand got %0d SUB cycles want 32", rs); end
    run_op(2'd3, 32'd100, 32'd7, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd2) begin errors++; $display("[TB] FAIL remu_100_7 got %0d want 2", r); end
    run_op(2'd2, 32'h80000000, 32'd3, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'h2AAAAAAA) begin errors++; $display("[TB] FAIL divu_msb got %h want 2aaaaaaa", r); end
    run_op(2'd3, 32'hFFFFFFFF, 32'h80000001, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'h7FFFFFFE) begin errors++; $display("[TB] FAIL remu_big got %h want 7ffffffe", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int dc, rf, rl, rc, ra, rs;
    run_op(2'd2, 32'd5, 32'd0, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu_zero got %h want ffffffff", r); end
    checks++; if (dc !== 1 || rc !== 0) begin
      errors++; $display("[TB] FAIL divu_zero_timing got done=%0d req=%0d want 1/0", dc, rc);
    end
    run_op(2'd3, 32'd5, 32'd0, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd5) begin errors++; $display("[TB] FAIL remu_zero got %h want 5", r); end
    checks++; if (dc !== 1 || rc !== 0) begin
      errors++; $display("[TB] FAIL remu_zero_timing got done=%0d req=%0d want 1/0", dc, rc);
    end
  endtask

  task automatic test_trivial();
    logic [31:0] r; int dc, rf, rl, rc, ra, rs;
    run_op(2'd0, 32'd0, 32'd5, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd0) begin errors++; $display("[TB] FAIL triv_mul got %h want 0", r); end
    checks++; if (dc !== TRIV_LAT) begin errors++; $display("[TB] FAIL triv_mul_latency got %0d want %0d", dc, TRIV_LAT); end
    run_op(2'd1, 32'h12345678, 32'd0, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd0) begin errors++; $display("[TB] FAIL triv_mulhu got %h want 0", r); end
    run_op(2'd2, 32'd9, 32'd1, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd9) begin errors++; $display("[TB] FAIL triv_divu got %h want 9", r); end
    checks++; if (dc !== TRIV_LAT) begin errors++; $display("[TB] FAIL triv_divu_latency got %0d want %0d", dc, TRIV_LAT); end
    run_op(2'd3, 32'd9, 32'd1, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd0) begin errors++; $display("[TB] FAIL triv_remu got %h want 0", r); end
  endtask

  task automatic test_kill();
    logic [31:0] r; int dc, rf, rl, rc, ra, rs;
    int done_seen = 0;
    run_op(2'd0, 32'd7, 32'd6, r, dc, rf, rl, rc, ra, rs);
    wait_idle();
    @(negedge clk);
    start = 1'b1; op_sel = 2'd0; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (done) done_seen++;
      if (cyc == 10) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL kill_busy_c10 got %b want 1", busy); end
      end
      if (cyc == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy_c11 got %b want 0", busy); end
        checks++; if (result !== 32'h2A) begin errors++; $display("[TB] FAIL kill_result got %h want 0000002a", result); end
      end
      if (cyc == 5) begin start = 1'b1; op_sel = 2'd2; op_a = 32'd50; op_b = 32'd5; end
      if (cyc == 10) kill = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL kill_done got %0d pulses want 0", done_seen); end
    run_op(2'd0, 32'd4, 32'd5, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd20 || dc !== 33) begin
      errors++; $display("[TB] FAIL after_kill got %0d at cycle %0d want 20 at 33", r, dc);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] r; int dc, rf, rl, rc, ra, rs;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op_sel = 2'd0; op_a = 32'd11; op_b = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || alu_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL async_rst got busy=%b req=%b done=%b want 0/0/0", busy, alu_req, done);
    end
    checks++; if (result !== 32'h0 || alu_op1 !== 32'h0) begin
      errors++; $display("[TB] FAIL async_rst_vals got result=%h op1=%h want 0/0", result, alu_op1);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(2'd0, 32'd3, 32'd3, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd9) begin errors++; $display("[TB] FAIL after_rst_mul got %0d want 9", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int dc, rf, rl, rc, ra, rs;
    run_op(2'd1, 32'h80000000, 32'd6, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'd3) begin errors++; $display("[TB] FAIL b2b_mulhu got %h want 3", r); end
    run_op(2'd2, 32'hFFFFFFFF, 32'h10, r, dc, rf, rl, rc, ra, rs);
    checks++; if (r !== 32'h0FFFFFFF) begin errors++; $display("[TB] FAIL b2b_divu got %h want 0fffffff", r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_trivial();
    test_kill();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
